// File: rtl/otp_pll_supervisor_if.sv
// Supervisor <-> PLL / OTP-domain signal bundle.
// The master side is the supervisor; the slave side is the PLL and its consumers.
interface otp_pll_supervisor_if;
  logic       lock_i;
  logic       retry_i;
  logic       pll_reset_o;
  logic       otp_rst_o;
  logic       ready_o;
  logic       fault_o;
  logic [7:0] relock_cnt_o;

  modport master (
    input  lock_i, retry_i,
    output pll_reset_o, otp_rst_o, ready_o, fault_o, relock_cnt_o
  );

  modport slave (
    output lock_i, retry_i,
    input  pll_reset_o, otp_rst_o, ready_o, fault_o, relock_cnt_o
  );
endinterface

// File: rtl/otp_pll_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable lock, then
// releases the OTP domain. Retries on timeout and latches FAULT after MAX_RETRIES.
module otp_pll_supervisor #(
  parameter int RESET_CYCLES  = 27,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 270,
  parameter int MAX_RETRIES   = 7
) (
  input  logic                 clkin,
  input  logic                 reset,
  otp_pll_supervisor_if.master sup
);

  localparam int MAX_T  = (RESET_CYCLES > LOCK_TIMEOUT)
                          ? ((RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES)
                          : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int TMR_W  = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIM = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST_PLL, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       relock_q, relock_d;
  logic [1:0]       lock_sync_q, lock_sync_d;
  logic             pll_reset_q, pll_reset_d;
  logic             otp_rst_q, otp_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lock_s;

  assign lock_sync_d = {lock_sync_q[0], sup.lock_i};
  assign lock_s      = lock_sync_q[1];

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_RST_PLL;
      timer_q     <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      lock_sync_q <= '0;
      pll_reset_q <= 1'b1;
      otp_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      lock_sync_q <= lock_sync_d;
      pll_reset_q <= pll_reset_d;
      otp_rst_q   <= otp_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Lock is checked before timeout so a lock arriving on the last cycle still wins.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    retry_d  = retry_q;
    relock_d = relock_q;
    unique case (state_q)
      S_RST_PLL: begin
        if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (timer_q == TO_LAST) begin
          retry_d = retry_q + 8'd1;
          state_d = (retry_d == RETRY_LIM) ? S_FAULT : S_RST_PLL;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (timer_q == STB_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        timer_d = '0;
        if (!lock_s) begin
          state_d = S_RST_PLL;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
      S_FAULT: begin
        timer_d = '0;
        if (sup.retry_i) begin
          state_d = S_RST_PLL;
          retry_d = '0;
        end
      end
      default: state_d = S_RST_PLL;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_comb begin
    pll_reset_d = (state_d == S_RST_PLL) || (state_d == S_FAULT);
    otp_rst_d   = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  assign sup.pll_reset_o  = pll_reset_q;
  assign sup.otp_rst_o    = otp_rst_q;
  assign sup.ready_o      = ready_q;
  assign sup.fault_o      = fault_q;
  assign sup.relock_cnt_o = relock_q;

endmodule

// File: tb/tb_otp_pll_supervisor.sv
// Scoreboard bench: stimulus predicts every output change (and a few checkpoints)
// by cycle number; the monitor compares each change against the queue head.
module tb_otp_pll_supervisor;
  // Shortened timeout/stable windows keep the retry and saturation scenarios short.
  localparam int RC = 27;
  localparam int LT = 600;
  localparam int SC = 40;
  localparam int MR = 7;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  always #5 clkin = ~clkin;

  otp_pll_supervisor_if bus();

  otp_pll_supervisor #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .sup   (bus)
  );

  // v = {pll_reset, otp_rst, ready, fault, relock_cnt[7:0]}
  typedef struct packed {
    logic [31:0] cyc;
    logic [11:0] v;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [11:0] prev = 12'hC00;

  always @(posedge clkin) cyc <= cyc + 1;

  function automatic logic [11:0] o(input logic [3:0] f, input int c);
    return {f, 8'(c)};
  endfunction

  task automatic push(input int unsigned c, input logic [11:0] v);
    exp_t e;
    int   i;
    e.cyc = c;
    e.v   = v;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) begin
      @(posedge clkin);
      #1;
    end
  endtask

  always @(negedge clkin) begin
    logic [11:0] s;
    s = {bus.pll_reset_o, bus.otp_rst_o, bus.ready_o, bus.fault_o, bus.relock_cnt_o};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL missed cyc=%0d exp=%h", q[0].cyc, q[0].v);
      q.delete(0);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      tests++;
      if (s !== q[0].v) begin
        fails++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, s, q[0].v);
      end
      q.delete(0);
    end else if (s !== prev) begin
      tests++; fails++;
      $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, s, prev);
    end
    prev = s;
  end

  // One-cycle lock drop from RUN, then a full re-lock back to RUN.
  task automatic drop1(input int c);
    int unsigned d;
    d = cyc;
    bus.lock_i = 1'b0;
    push(d + 3,           o(4'b1100, c));
    push(d + 3 + RC,      o(4'b0100, c));
    push(d + RC + SC + 4, o(4'b0010, c));
    wait_to(d + 1);
    bus.lock_i = 1'b1;
    wait_to(d + RC + SC + 6);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned r, l, g, p, f, w, e;
    bus.lock_i  = 1'b0;
    bus.retry_i = 1'b0;

    // Reset state, then a 27-cycle PLL reset pulse and first lock.
    wait_to(3);
    push(3, o(4'b1100, 0));
    reset = 1'b0;
    r = cyc;
    push(r + RC - 1, o(4'b1100, 0));
    push(r + RC,     o(4'b0100, 0));
    wait_to(r + RC + 100);
    l = cyc;
    bus.lock_i = 1'b1;
    push(l + SC + 2, o(4'b0100, 0));
    push(l + SC + 3, o(4'b0010, 0));
    wait_to(l + SC + 8);

    // retry_i outside FAULT must not disturb RUN.
    bus.retry_i = 1'b1;
    wait_to(cyc + 1);
    bus.retry_i = 1'b0;
    push(cyc + 3, o(4'b0010, 0));
    wait_to(cyc + 5);

    // Lock loss from RUN.
    drop1(1);

    // Glitch in the middle of STABLE restarts the stable window.
    w = cyc;
    bus.lock_i = 1'b0;
    push(w + 3,      o(4'b1100, 2));
    push(w + 3 + RC, o(4'b0100, 2));
    wait_to(w + 3 + RC + 5);
    l = cyc;
    bus.lock_i = 1'b1;
    g = l + 3 + SC / 2;
    wait_to(g);
    bus.lock_i = 1'b0;
    wait_to(g + 5);
    bus.lock_i = 1'b1;
    push(g + 8 + SC, o(4'b0010, 2));
    wait_to(g + SC + 12);

    // Permanent lock loss: MR pulses, then FAULT; retry leaves FAULT.
    p = cyc + 3;
    bus.lock_i = 1'b0;
    push(p, o(4'b1100, 3));
    for (int k = 0; k < MR; k++) begin
      push(p + RC,      o(4'b0100, 3));
      push(p + RC + LT, (k == MR - 1) ? o(4'b1101, 3) : o(4'b1100, 3));
      p = p + RC + LT;
    end
    push(p + 50, o(4'b1101, 3));
    wait_to(p + 60);
    f = cyc;
    bus.retry_i = 1'b1;
    push(f + 1,            o(4'b1100, 3));
    push(f + 1 + RC,       o(4'b0100, 3));
    push(f + 1 + RC + LT,  o(4'b1100, 3));
    w = f + 1 + 2 * RC + LT;
    push(w, o(4'b0100, 3));
    wait_to(f + 1);
    bus.retry_i = 1'b0;

    // Asynchronous reset mid-WAIT_LOCK.
    wait_to(w + LT / 2);
    #1;
    push(cyc, o(4'b1100, 0));
    reset = 1'b1;
    wait_to(cyc + 3);
    reset = 1'b0;
    r = cyc;
    push(r + RC, o(4'b0100, 0));
    wait_to(r + RC + 10);
    l = cyc;
    bus.lock_i = 1'b1;
    push(l + SC + 3, o(4'b0010, 0));
    wait_to(l + SC + 6);
    drop1(1);

    // Asynchronous reset during RUN clears relock_cnt.
    #1;
    push(cyc, o(4'b1100, 0));
    reset = 1'b1;
    wait_to(cyc + 3);
    reset = 1'b0;
    r = cyc;
    push(r + RC,          o(4'b0100, 0));
    push(r + RC + 1 + SC, o(4'b0010, 0));
    wait_to(r + RC + SC + 5);

    // relock_cnt saturation.
    for (int n = 1; n <= 260; n++) drop1((n > 255) ? 255 : n);
    e = cyc + 2;
    push(e, o(4'b0010, 255));
    wait_to(e + 2);

    while (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL pending cyc=%0d exp=%h", q[0].cyc, q[0].v);
      q.delete(0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
